// File: rtl/axi_pkg.sv
// Shared constants, engine state encoding and helpers for the AXI burst read RAM.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;
   localparam logic [1:0] BURST_RSVD  = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ACTIVE
   } engine_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational beat address, active byte-lane window and legality check for one burst beat.
module axi_burst_addr_gen
   import axi_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int STROBE_WIDTH  = 4,
   parameter int LANE_WIDTH    = 2
) (
   input  logic [ADDRESS_WIDTH-1:0] start_addr,
   input  logic [7:0]               len,
   input  logic [2:0]               size,
   input  logic [1:0]               burst,
   input  logic [7:0]               beat,
   output logic [ADDRESS_WIDTH-1:0] next_addr,
   output logic [LANE_WIDTH-1:0]    lower,
   output logic [LANE_WIDTH-1:0]    upper,
   output logic                     err
);

   // Wide enough that beat*bytes and the wrap span never overflow before truncation.
   localparam int CW         = ADDRESS_WIDTH + 16;
   localparam int LOG_STROBE = clog2(STROBE_WIDTH);

   logic [CW-1:0] bytes, span, aligned, base, step, addr_w, beat_aligned;

   always_comb begin
      bytes   = CW'(1) << size;
      span    = bytes * (CW'(len) + CW'(1));
      aligned = CW'(start_addr) & ~(bytes - CW'(1));
      base    = CW'(start_addr) & ~(span - CW'(1));
      step    = CW'(beat) * bytes;
      addr_w  = CW'(start_addr);
      if (beat != 8'd0) begin
         case (burst)
            BURST_INCR: addr_w = aligned + step;
            BURST_WRAP: addr_w = base + ((aligned - base + step) & (span - CW'(1)));
            default:    addr_w = CW'(start_addr);
         endcase
      end
      beat_aligned = addr_w & ~(bytes - CW'(1));
      next_addr    = addr_w[ADDRESS_WIDTH-1:0];
      lower        = LANE_WIDTH'(addr_w & CW'(STROBE_WIDTH - 1));
      upper        = LANE_WIDTH'((beat_aligned & CW'(STROBE_WIDTH - 1)) + bytes - CW'(1));
      err          = (burst == BURST_RSVD) || (int'(size) > LOG_STROBE) ||
                     ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
   end

endmodule

// File: rtl/axi_burst_read_ram.sv
// AXI4 read-only slave over a byte RAM: queued AR requests, FIXED/INCR/WRAP bursts, SLVERR, backdoor preload.
module axi_burst_read_ram
   import axi_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 8,
   parameter int AR_FIFO_DEPTH = 2,
   parameter int STROBE_WIDTH  = DATA_WIDTH / 8
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [ADDRESS_WIDTH-1:0] araddr,
   input  logic [7:0]               arlen,
   input  logic [2:0]               arsize,
   input  logic [1:0]               arburst,
   input  logic                     arvalid,
   output logic                     arready,
   output logic [DATA_WIDTH-1:0]    rdata,
   output logic [1:0]               rresp,
   output logic                     rlast,
   output logic                     rvalid,
   input  logic                     rready,
   input  logic                     init_we,
   input  logic [ADDRESS_WIDTH-1:0] init_addr,
   input  logic [7:0]               init_data
);

   localparam int LW   = (clog2(STROBE_WIDTH) > 0) ? clog2(STROBE_WIDTH) : 1;
   localparam int IW   = (clog2(AR_FIFO_DEPTH) > 0) ? clog2(AR_FIFO_DEPTH) : 1;
   localparam int CNTW = clog2(AR_FIFO_DEPTH + 1);

   logic [7:0]               ram [2**ADDRESS_WIDTH];

   logic [ADDRESS_WIDTH-1:0] fifo_addr  [AR_FIFO_DEPTH];
   logic [7:0]               fifo_len   [AR_FIFO_DEPTH];
   logic [2:0]               fifo_size  [AR_FIFO_DEPTH];
   logic [1:0]               fifo_burst [AR_FIFO_DEPTH];
   logic [IW-1:0]            wr_ptr, rd_ptr;
   logic [CNTW-1:0]          count;
   logic                     fifo_full, fifo_empty, push, pop;

   engine_state_t            state;
   logic [ADDRESS_WIDTH-1:0] cur_addr;
   logic [7:0]               cur_len, beat;
   logic [2:0]               cur_size;
   logic [1:0]               cur_burst;

   logic [ADDRESS_WIDTH-1:0] beat_addr;
   logic [LW-1:0]            lower, upper;
   logic                     burst_err, load_beat;
   logic [DATA_WIDTH-1:0]    beat_data;

   assign fifo_full  = (count == CNTW'(AR_FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign arready    = !fifo_full && !areset;
   assign push       = arvalid && arready;
   assign pop        = (state == IDLE) && !fifo_empty;
   assign load_beat  = (state == LOAD) || ((state == ACTIVE) && rready && !rlast);

   // Contents deliberately survive reset so a preloaded image stays valid across test runs.
   always_ff @(posedge aclk) begin
      if (init_we) ram[init_addr] <= init_data;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_addr[wr_ptr]  <= araddr;
            fifo_len[wr_ptr]   <= arlen;
            fifo_size[wr_ptr]  <= arsize;
            fifo_burst[wr_ptr] <= arburst;
            wr_ptr <= (wr_ptr == IW'(AR_FIFO_DEPTH - 1)) ? '0 : wr_ptr + IW'(1);
         end
         if (pop) rd_ptr <= (rd_ptr == IW'(AR_FIFO_DEPTH - 1)) ? '0 : rd_ptr + IW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

   axi_burst_addr_gen #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .STROBE_WIDTH  (STROBE_WIDTH),
      .LANE_WIDTH    (LW)
   ) u_addr_gen (
      .start_addr (cur_addr),
      .len        (cur_len),
      .size       (cur_size),
      .burst      (cur_burst),
      .beat       (beat),
      .next_addr  (beat_addr),
      .lower      (lower),
      .upper      (upper),
      .err        (burst_err)
   );

   always_comb begin
      beat_data = '0;
      for (int i = 0; i < STROBE_WIDTH; i++) begin
         if ((i >= int'(lower)) && (i <= int'(upper)))
            beat_data[8*i +: 8] = ram[beat_addr - ADDRESS_WIDTH'(lower) + ADDRESS_WIDTH'(i)];
      end
   end

   // The next beat is loaded on the same edge that accepts the current one, so beats are gapless.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state     <= IDLE;
         rvalid    <= 1'b0;
         rlast     <= 1'b0;
         rdata     <= '0;
         rresp     <= RESP_OKAY;
         beat      <= '0;
         cur_addr  <= '0;
         cur_len   <= '0;
         cur_size  <= '0;
         cur_burst <= '0;
      end else begin
         if (load_beat) begin
            rdata  <= burst_err ? '0 : beat_data;
            rresp  <= burst_err ? RESP_SLVERR : RESP_OKAY;
            rlast  <= (beat == cur_len);
            rvalid <= 1'b1;
            beat   <= beat + 8'd1;
         end
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  cur_addr  <= fifo_addr[rd_ptr];
                  cur_len   <= fifo_len[rd_ptr];
                  cur_size  <= fifo_size[rd_ptr];
                  cur_burst <= fifo_burst[rd_ptr];
                  beat      <= '0;
                  state     <= LOAD;
               end
            end
            LOAD: state <= ACTIVE;
            ACTIVE: begin
               if (rready && rlast) begin
                  rvalid <= 1'b0;
                  rlast  <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_burst_read_ram.sv
// Self-checking bench for axi_burst_read_ram: directed scenarios plus random bursts against a
// behavioural model that walks burst addresses beat by beat over a shadow copy of the RAM.
module tb_axi_burst_read_ram;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [7:0]  araddr = '0;
   logic [7:0]  arlen = '0;
   logic [2:0]  arsize = '0;
   logic [1:0]  arburst = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready = 1'b0;
   logic        init_we = 1'b0;
   logic [7:0]  init_addr = '0;
   logic [7:0]  init_data = '0;

   always #5 aclk = ~aclk;

   axi_burst_read_ram #(
      .DATA_WIDTH    (32),
      .ADDRESS_WIDTH (8),
      .AR_FIFO_DEPTH (2)
   ) dut (
      .aclk      (aclk),
      .areset    (areset),
      .araddr    (araddr),
      .arlen     (arlen),
      .arsize    (arsize),
      .arburst   (arburst),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata     (rdata),
      .rresp     (rresp),
      .rlast     (rlast),
      .rvalid    (rvalid),
      .rready    (rready),
      .init_we   (init_we),
      .init_addr (init_addr),
      .init_data (init_data)
   );

   typedef struct {
      int addr;
      int len;
      int size;
      int burst;
   } ar_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   ar_t         ar_q[$];
   beat_t       exp_q[$];
   logic [7:0]  mem [256];
   int          pass_count = 0;
   int          check_count = 0;
   int          fail_count = 0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic [1:0]  prev_resp = '0;
   logic        prev_last = 1'b0;
   bit          gap_on = 1'b0;
   int          gap_cnt = 0;
   int          last_gap = -1;

   function automatic ar_t mkAr(input int a, input int l, input int s, input int b);
      ar_t r;
      r.addr = a;
      r.len = l;
      r.size = s;
      r.burst = b;
      return r;
   endfunction

   function automatic bit modelErr(input ar_t r);
      return (r.burst == 3) || (r.size > 2) ||
             ((r.burst == 2) && !(r.len == 1 || r.len == 3 || r.len == 7 || r.len == 15));
   endfunction

   // Walks the burst one beat at a time: step to the next aligned address, wrapping at the span.
   function automatic int beatAddr(input ar_t r, input int n);
      int bytes = 1 << r.size;
      int span = bytes * (r.len + 1);
      int base = (r.addr / span) * span;
      int a = r.addr;
      if (r.burst == 0) return r.addr;
      for (int k = 1; k <= n; k++) begin
         a = (a / bytes) * bytes + bytes;
         if ((r.burst == 2) && (a >= base + span)) a = base;
      end
      return a % 256;
   endfunction

   function automatic logic [31:0] modelData(input ar_t r, input int n);
      int bytes = 1 << r.size;
      int a = beatAddr(r, n);
      int lower = a % 4;
      int upper = ((a / bytes) * bytes) % 4 + bytes - 1;
      logic [31:0] d = '0;
      for (int i = lower; i <= upper; i++) d[8*i +: 8] = mem[(a - lower + i) % 256];
      return d;
   endfunction

   function automatic void pushExpected(input ar_t r);
      beat_t b;
      for (int n = 0; n <= r.len; n++) begin
         b.data = modelErr(r) ? 32'd0 : modelData(r, n);
         b.resp = modelErr(r) ? 2'd2 : 2'd0;
         b.last = (n == r.len);
         exp_q.push_back(b);
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      assert (observed === expected) pass_count++;
      else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // One cycle at the falling edge: check held data, drive rready/AR, score any accepted beat.
   task automatic applyStimulus(input int pct);
      beat_t e;
      @(negedge aclk);
      if (prev_stall) begin
         checkOutput("hold_valid", 32'(rvalid), 1);
         checkOutput("hold_data", rdata, prev_data);
         checkOutput("hold_resp", 32'(rresp), 32'(prev_resp));
         checkOutput("hold_last", 32'(rlast), 32'(prev_last));
      end
      rready = ($urandom_range(99) < pct);
      if (ar_q.size() > 0) begin
         arvalid = 1'b1;
         araddr  = 8'(ar_q[0].addr);
         arlen   = 8'(ar_q[0].len);
         arsize  = 3'(ar_q[0].size);
         arburst = 2'(ar_q[0].burst);
         if (arready) begin
            pushExpected(ar_q[0]);
            void'(ar_q.pop_front());
         end
      end else begin
         arvalid = 1'b0;
      end
      if (gap_on) begin
         if (!rvalid) gap_cnt++;
         else begin
            last_gap = gap_cnt;
            gap_on = 1'b0;
         end
      end
      if (rvalid && rready) begin
         checkOutput("beat_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("beat_data", rdata, e.data);
            checkOutput("beat_resp", 32'(rresp), 32'(e.resp));
            checkOutput("beat_last", 32'(rlast), 32'(e.last));
         end
         if (rlast) begin
            gap_on = 1'b1;
            gap_cnt = 0;
         end
      end
      prev_stall = rvalid && !rready;
      prev_data  = rdata;
      prev_resp  = rresp;
      prev_last  = rlast;
   endtask

   task automatic drain(input int pct, input int budget);
      int n = 0;
      while ((ar_q.size() > 0 || exp_q.size() > 0 || rvalid) && n < budget) begin
         applyStimulus(pct);
         n++;
      end
      checkOutput("drain_in_budget", 32'(n < budget), 1);
      arvalid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] incr_exp [4] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
      int w;

      // Reset values with areset held high.
      repeat (2) @(negedge aclk);
      checkOutput("rst_rvalid", 32'(rvalid), 0);
      checkOutput("rst_rlast", 32'(rlast), 0);
      checkOutput("rst_rdata", rdata, 0);
      checkOutput("rst_rresp", 32'(rresp), 0);
      checkOutput("rst_arready", 32'(arready), 0);
      areset = 1'b0;
      @(negedge aclk);
      checkOutput("arready_after_rst", 32'(arready), 1);

      // Sim-init image: byte i = i.
      for (int i = 0; i < 256; i++) begin
         init_we = 1'b1;
         init_addr = 8'(i);
         init_data = 8'(i);
         mem[i] = 8'(i);
         @(negedge aclk);
      end
      init_we = 1'b0;

      // INCR 0x10 len3 size2 with rready held high: latency and gapless beats.
      araddr = 8'h10; arlen = 8'd3; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1; rready = 1'b1;
      checkOutput("arready_idle", 32'(arready), 1);
      @(negedge aclk);
      arvalid = 1'b0;
      checkOutput("latency_edge1", 32'(rvalid), 0);
      @(negedge aclk);
      checkOutput("latency_edge2", 32'(rvalid), 0);
      for (int b = 0; b < 4; b++) begin
         @(negedge aclk);
         checkOutput("incr_valid", 32'(rvalid), 1);
         checkOutput("incr_data", rdata, incr_exp[b]);
         checkOutput("incr_last", 32'(rlast), 32'(b == 3));
         checkOutput("incr_resp", 32'(rresp), 0);
      end
      @(negedge aclk);
      checkOutput("incr_done", 32'(rvalid), 0);

      // Narrow INCR, WRAP, illegal WRAP length, reserved burst type, oversize beat.
      ar_q.push_back(mkAr(8'h21, 2, 0, 1));
      ar_q.push_back(mkAr(8'h38, 3, 2, 2));
      ar_q.push_back(mkAr(8'h38, 2, 2, 2));
      ar_q.push_back(mkAr(8'h04, 1, 2, 3));
      ar_q.push_back(mkAr(8'h08, 1, 3, 1));
      drain(70, 400);

      // Three back-to-back ARs with rready low: FIFO fills, then drains in order with stalls.
      ar_q.push_back(mkAr(8'h50, 3, 2, 1));
      ar_q.push_back(mkAr(8'h68, 1, 2, 2));
      ar_q.push_back(mkAr(8'h71, 2, 1, 0));
      repeat (6) applyStimulus(0);
      checkOutput("arready_full", 32'(arready), 0);
      drain(50, 400);

      // Two queued bursts at full rate: IDLE then LOAD separate them.
      last_gap = -1;
      ar_q.push_back(mkAr(8'h80, 1, 2, 1));
      ar_q.push_back(mkAr(8'h90, 1, 2, 1));
      drain(100, 100);
      checkOutput("idle_gap", 32'(last_gap), 2);

      // Backdoor write on the edge that loads a beat returns the old byte.
      araddr = 8'hC0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd1; arvalid = 1'b1; rready = 1'b0;
      @(negedge aclk);
      arvalid = 1'b0;
      @(negedge aclk);
      init_we = 1'b1; init_addr = 8'hC0; init_data = 8'hA5;
      @(negedge aclk);
      init_we = 1'b0;
      checkOutput("same_edge_valid", 32'(rvalid), 1);
      checkOutput("same_edge_old", rdata, 32'h000000C0);
      rready = 1'b1;
      @(negedge aclk);
      checkOutput("same_edge_done", 32'(rvalid), 0);
      mem[8'hC0] = 8'hA5;
      ar_q.push_back(mkAr(8'hC0, 0, 0, 1));
      drain(100, 50);

      // Reset two beats into a len7 burst: no further beats, FIFO emptied.
      araddr = 8'h40; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1; rready = 1'b0;
      @(negedge aclk);
      arvalid = 1'b0;
      w = 0;
      while (!rvalid && w < 8) begin
         @(negedge aclk);
         w++;
      end
      checkOutput("rst_burst_start", 32'(rvalid), 1);
      rready = 1'b1;
      @(negedge aclk);
      checkOutput("rst_burst_beat1", rdata, 32'h47464544);
      @(negedge aclk);
      areset = 1'b1;
      @(negedge aclk);
      checkOutput("midrst_rvalid", 32'(rvalid), 0);
      checkOutput("midrst_arready", 32'(arready), 0);
      areset = 1'b0;
      @(negedge aclk);
      checkOutput("postrst_rvalid", 32'(rvalid), 0);
      checkOutput("postrst_arready", 32'(arready), 1);
      prev_stall = 1'b0;
      ar_q.push_back(mkAr(8'h44, 1, 2, 1));
      drain(100, 50);

      // Scramble part of the RAM through the backdoor, then random bursts.
      for (int i = 0; i < 64; i++) begin
         init_we = 1'b1;
         init_addr = 8'($urandom_range(255));
         init_data = 8'($urandom_range(255));
         mem[init_addr] = init_data;
         @(negedge aclk);
      end
      init_we = 1'b0;
      for (int k = 0; k < 24; k++) begin
         ar_t r;
         r.addr = int'($urandom_range(255));
         r.burst = int'($urandom_range(3));
         r.size = int'($urandom_range(3));
         if (r.burst == 2) begin
            case ($urandom_range(4))
               0: r.len = 2;
               1: r.len = 1;
               2: r.len = 3;
               3: r.len = 7;
               default: r.len = 15;
            endcase
         end else begin
            r.len = int'($urandom_range(7));
         end
         ar_q.push_back(r);
      end
      drain(60, 4000);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
